mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-word memory port between the instruction cache refill interface and the data cache miss/writeback interface.
- Sits between the two caches and the memory subsystem and replaces the direct cache-to-memory wiring.
- Arbitration is two-way round-robin; the data cache wins when both request and neither has a grant history.
- Each grant covers exactly one word transaction; the downstream request is held stable until memory signals ready.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports
STAT_WIDTH, 32, width of statistics counters (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
icache_mem_addr  in  ADDR_WIDTH  I-cache word address
icache_mem_req  in  1  I-cache request, held until ready
icache_mem_rdata  out  DATA_WIDTH  read data to I-cache
icache_mem_ready  out  1  single-cycle completion to I-cache
dcache_mem_addr  in  ADDR_WIDTH  D-cache word address
dcache_mem_wdata  in  DATA_WIDTH  D-cache write data
dcache_mem_be  in  4  D-cache byte enables
dcache_mem_we  in  1  1 = write, 0 = read
dcache_mem_req  in  1  D-cache request, held until ready
dcache_mem_rdata  out  DATA_WIDTH  read data to D-cache
dcache_mem_ready  out  1  single-cycle completion to D-cache
mem_addr  out  ADDR_WIDTH  latched address to memory
mem_wdata  out  DATA_WIDTH  latched write data
mem_be  out  4  latched byte enables (4'hF for I-cache)
mem_we  out  1  latched write enable (0 for I-cache)
mem_req  out  1  memory request, held until mem_ready
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  in  1  memory completion pulse
stat_icache_grants  out  STAT_WIDTH  I-cache grant count
stat_dcache_grants  out  STAT_WIDTH  D-cache grant count
stat_contention  out  STAT_WIDTH  cycles with a request pending but not granted

Behaviour:
- Reset (asynchronous, any state): state=IDLE; mem_req=0; mem_addr/mem_wdata/mem_be/mem_we=0; last_grant=I, so the D-cache wins the first tie; stat counters=0.
- Reset mid-transaction abandons it; no ready is emitted.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, single requester: grant it.
- IDLE, both requesting: grant the side that is not last_grant.
- On grant: register the requester's addr/wdata/be/we onto mem_*; set mem_req=1; update last_grant; enter BUSY_x.
- I-cache grants drive mem_be=4'hF and mem_we=0.
- Grant latency: a request seen in IDLE at cycle N gives mem_req=1 in cycle N+1.
- BUSY_x: mem_* held constant and requester inputs ignored.
- BUSY_x with mem_ready=1: x_mem_ready=1 combinationally in the same cycle, x_mem_rdata=mem_rdata; the next edge sets mem_req=0 and state=IDLE.
- No back-to-back issue: IDLE lasts at least one cycle, so the requester's updated req is sampled only after it has seen ready.
- Minimum transaction length is 2 cycles plus memory latency.
- The non-granted x_mem_ready is always 0.
- x_mem_rdata equals mem_rdata when x is granted, 0 otherwise.
- A requester dropping req while in BUSY is a protocol violation: the latched transaction still completes and ready still pulses.
- A mem_ready arriving in IDLE is ignored.
- A single requester re-requesting is granted again immediately after its IDLE cycle; round-robin only matters when both are pending.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined: the stat_* counters are active:
  - grants increment on each grant edge;
  - contention increments each cycle a non-granted requester has req=1;
  - all counters saturate at all-ones.
- Undefined: stat_* ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding localparams (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - requester ID constants (REQ_I=1'b0, REQ_D=1'b1);
  - BE_FULL=4'hF.
- One natural sub-module, rr_arbiter2: combinational 2-way round-robin pick from req vector and last_grant.
- Counters stay inline.

Test Plan:
1. Reset check: rst_n=0 asserted mid-BUSY_D -> mem_req=0 and state IDLE immediately; dcache_mem_ready stays 0; after release, a lone I-cache request is granted next cycle.
2. Lone I-cache read: icache_mem_req=1, addr=0x100; memory returns 0xDEADBEEF after 3 cycles -> mem_be=F and mem_we=0 throughout; icache_mem_ready pulses exactly once with rdata 0xDEADBEEF.
3. Simultaneous requests after reset: D-cache write addr=0x2000, wdata=0x12345678, be=0x3 -> D-cache is served first with mem_be=0x3 and mem_we=1; I-cache is served next.
4. Both requesting continuously for 6 transactions -> grants alternate D,I,D,I,D,I; no requester ever waits more than one transaction.
5. D-cache holds req across its ready cycle and changes addr 0x40 to 0x44 after ready -> second transaction uses 0x44; no duplicate transaction at 0x40.
6. With MEM_PORT_ARBITER_STATS_EN, the scenario 4 traffic -> stat_icache_grants=3, stat_dcache_grants=3, stat_contention equals the counted waiting cycles; without the macro all stat_* read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache memory port arbiter: FSM states,
// requester IDs and the full-word byte-enable value.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam logic       REQ_I   = 1'b0;
   localparam logic       REQ_D   = 1'b1;
   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Combinational two-way round-robin pick: on a tie the side that did not win
// last time is chosen; a lone requester always wins.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = REQ_I;
      if (&req)
         gnt_id = ~last_grant;
      else if (req[REQ_D])
         gnt_id = REQ_D;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-word memory port between I-cache refills and D-cache traffic.
// Optional grant/contention counters are built when MEM_PORT_ARBITER_STATS_EN is defined.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] icache_mem_addr,
   input  logic                  icache_mem_req,
   output logic [DATA_WIDTH-1:0] icache_mem_rdata,
   output logic                  icache_mem_ready,
   input  logic [ADDR_WIDTH-1:0] dcache_mem_addr,
   input  logic [DATA_WIDTH-1:0] dcache_mem_wdata,
   input  logic [3:0]            dcache_mem_be,
   input  logic                  dcache_mem_we,
   input  logic                  dcache_mem_req,
   output logic [DATA_WIDTH-1:0] dcache_mem_rdata,
   output logic                  dcache_mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   output logic                  mem_we,
   output logic                  mem_req,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [STAT_WIDTH-1:0] stat_icache_grants,
   output logic [STAT_WIDTH-1:0] stat_dcache_grants,
   output logic [STAT_WIDTH-1:0] stat_contention
);

   arb_state_t state;
   logic       last_grant;
   logic [1:0] req_vec;
   logic       gnt_valid;
   logic       gnt_id;

   // Bit position of each request matches its requester ID.
   assign req_vec = {dcache_mem_req, icache_mem_req};

   rr_arbiter2 u_rr (
      .req        (req_vec),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         mem_we     <= 1'b0;
         last_grant <= REQ_I;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  mem_req    <= 1'b1;
                  last_grant <= gnt_id;
                  if (gnt_id == REQ_D) begin
                     mem_addr  <= dcache_mem_addr;
                     mem_wdata <= dcache_mem_wdata;
                     mem_be    <= dcache_mem_be;
                     mem_we    <= dcache_mem_we;
                     state     <= BUSY_D;
                  end else begin
                     mem_addr  <= icache_mem_addr;
                     mem_wdata <= '0;
                     mem_be    <= BE_FULL;
                     mem_we    <= 1'b0;
                     state     <= BUSY_I;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               // Always drop back to IDLE so a held request is re-sampled only after its ready.
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign icache_mem_ready = (state == BUSY_I) && mem_ready;
   assign dcache_mem_ready = (state == BUSY_D) && mem_ready;
   assign icache_mem_rdata = (state == BUSY_I) ? mem_rdata : '0;
   assign dcache_mem_rdata = (state == BUSY_D) ? mem_rdata : '0;

`ifdef MEM_PORT_ARBITER_STATS_EN
   logic [STAT_WIDTH-1:0] cnt_i;
   logic [STAT_WIDTH-1:0] cnt_d;
   logic [STAT_WIDTH-1:0] cnt_cont;
   logic                  grant_i;
   logic                  grant_d;
   logic                  contention;

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign grant_i    = (state == IDLE) && gnt_valid && (gnt_id == REQ_I);
   assign grant_d    = (state == IDLE) && gnt_valid && (gnt_id == REQ_D);
   // A waiting requester is the tie loser in IDLE, or the other side while busy.
   assign contention = ((state == IDLE) && (&req_vec)) ||
                       ((state == BUSY_I) && dcache_mem_req) ||
                       ((state == BUSY_D) && icache_mem_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_i    <= '0;
         cnt_d    <= '0;
         cnt_cont <= '0;
      end else begin
         if (grant_i)    cnt_i    <= sat_inc(cnt_i);
         if (grant_d)    cnt_d    <= sat_inc(cnt_d);
         if (contention) cnt_cont <= sat_inc(cnt_cont);
      end
   end

   assign stat_icache_grants = cnt_i;
   assign stat_dcache_grants = cnt_d;
   assign stat_contention    = cnt_cont;
`else
   assign stat_icache_grants = '0;
   assign stat_dcache_grants = '0;
   assign stat_contention    = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a transaction-level
// reference model of the round-robin memory port.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] icache_mem_addr = '0;
   logic          icache_mem_req = 1'b0;
   logic [DW-1:0] icache_mem_rdata;
   logic          icache_mem_ready;
   logic [AW-1:0] dcache_mem_addr = '0;
   logic [DW-1:0] dcache_mem_wdata = '0;
   logic [3:0]    dcache_mem_be = '0;
   logic          dcache_mem_we = 1'b0;
   logic          dcache_mem_req = 1'b0;
   logic [DW-1:0] dcache_mem_rdata;
   logic          dcache_mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_we;
   logic          mem_req;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic [SW-1:0] stat_icache_grants;
   logic [SW-1:0] stat_dcache_grants;
   logic [SW-1:0] stat_contention;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .icache_mem_addr    (icache_mem_addr),
      .icache_mem_req     (icache_mem_req),
      .icache_mem_rdata   (icache_mem_rdata),
      .icache_mem_ready   (icache_mem_ready),
      .dcache_mem_addr    (dcache_mem_addr),
      .dcache_mem_wdata   (dcache_mem_wdata),
      .dcache_mem_be      (dcache_mem_be),
      .dcache_mem_we      (dcache_mem_we),
      .dcache_mem_req     (dcache_mem_req),
      .dcache_mem_rdata   (dcache_mem_rdata),
      .dcache_mem_ready   (dcache_mem_ready),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_be             (mem_be),
      .mem_we             (mem_we),
      .mem_req            (mem_req),
      .mem_rdata          (mem_rdata),
      .mem_ready          (mem_ready),
      .stat_icache_grants (stat_icache_grants),
      .stat_dcache_grants (stat_dcache_grants),
      .stat_contention    (stat_contention)
   );

   typedef struct {
      bit          who;   // 0 = I-cache, 1 = D-cache
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
   } txn_t;

   typedef struct {
      bit          who;
      logic [31:0] rdata;
   } rdy_t;

   txn_t exp_txn[$];
   rdy_t exp_rdy[$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: one transaction at a time, ties alternate starting with the D-cache.
   bit          m_busy = 1'b0;
   bit          m_owner = 1'b0;
   bit          m_last = 1'b0;
   int          m_txn = 0;
   int          m_done_i = 0;
   int          m_done_d = 0;
   int unsigned m_gi = 0;
   int unsigned m_gd = 0;
   int unsigned m_cont = 0;

   initial begin : model
      bit   pick;
      txn_t t;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b0;
            m_gi = 0;
            m_gd = 0;
            m_cont = 0;
            exp_txn.delete();
            exp_rdy.delete();
         end else if (m_busy) begin
            if (m_owner ? icache_mem_req : dcache_mem_req) m_cont++;
            if (mem_ready) begin
               m_busy = 1'b0;
               if (m_owner) m_done_d++;
               else m_done_i++;
            end
         end else if (icache_mem_req || dcache_mem_req) begin
            if (icache_mem_req && dcache_mem_req) begin
               pick = !m_last;
               m_cont++;
            end else begin
               pick = dcache_mem_req;
            end
            t.who = pick;
            if (pick) begin
               t.addr = dcache_mem_addr; t.wdata = dcache_mem_wdata;
               t.be = dcache_mem_be;     t.we = dcache_mem_we;
               m_gd++;
            end else begin
               t.addr = icache_mem_addr; t.wdata = 32'h0;
               t.be = 4'hF;              t.we = 1'b0;
               m_gi++;
            end
            exp_txn.push_back(t);
            m_busy = 1'b1;
            m_owner = pick;
            m_last = pick;
            m_txn++;
         end
      end
   end

   // Monitor: compares every memory-side issue and every ready against the queues.
   initial begin : monitor
      txn_t t;
      txn_t held;
      rdy_t r;
      bit   prev = 1'b0;
      held = '{who: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, we: 1'b0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
         end else begin
            if (mem_req && !prev) begin
               if (exp_txn.size() == 0) begin
                  chk("spurious_req", 128'(mem_req), 128'(0));
               end else begin
                  t = exp_txn.pop_front();
                  chk(t.who ? "txn_d" : "txn_i",
                      128'({mem_addr, (t.who ? mem_wdata : 32'h0), mem_be, mem_we}),
                      128'({t.addr, t.wdata, t.be, t.we}));
               end
               held.addr = mem_addr; held.wdata = mem_wdata;
               held.be = mem_be;     held.we = mem_we;
            end else begin
               if (exp_txn.size() > 0) begin
                  void'(exp_txn.pop_front());
                  chk("grant_latency", 128'(mem_req & ~prev), 128'(1));
               end
               if (mem_req)
                  chk("hold", 128'({mem_addr, mem_wdata, mem_be, mem_we}),
                      128'({held.addr, held.wdata, held.be, held.we}));
            end
            if (exp_rdy.size() > 0) begin
               r = exp_rdy.pop_front();
               chk("ready_vec", 128'({icache_mem_ready, dcache_mem_ready}),
                   128'(r.who ? 2'b01 : 2'b10));
               chk("rdata", 128'(r.who ? dcache_mem_rdata : icache_mem_rdata), 128'(r.rdata));
               chk("other_rdata", 128'(r.who ? icache_mem_rdata : dcache_mem_rdata), 128'(0));
            end else begin
               chk("no_ready", 128'({icache_mem_ready, dcache_mem_ready}), 128'(0));
            end
            prev = mem_req;
         end
      end
   end

   // Stimulus: requesters and the memory responder, driven just after each rising edge.
   bit          rand_en = 1'b0;
   bit          mem_hold = 1'b0;
   int unsigned keep_pct = 50;
   int          seen_i = 0;
   int          seen_d = 0;
   int          served_txn = 0;
   int unsigned lat = 0;

   task automatic drive_reqs();
      if (icache_mem_req && m_done_i != seen_i) begin
         seen_i = m_done_i;
         if (rand_en && $urandom_range(0, 99) < keep_pct) icache_mem_addr = $urandom;
         else icache_mem_req = 1'b0;
      end else if (!icache_mem_req && rand_en && $urandom_range(0, 2) == 0) begin
         icache_mem_req = 1'b1;
         icache_mem_addr = $urandom;
      end
      if (dcache_mem_req && m_done_d != seen_d) begin
         seen_d = m_done_d;
         if (rand_en && $urandom_range(0, 99) < keep_pct) begin
            dcache_mem_addr = $urandom; dcache_mem_wdata = $urandom;
            dcache_mem_be = 4'($urandom_range(0, 15)); dcache_mem_we = 1'($urandom_range(0, 1));
         end else begin
            dcache_mem_req = 1'b0;
         end
      end else if (!dcache_mem_req && rand_en && $urandom_range(0, 2) == 0) begin
         dcache_mem_req = 1'b1;
         dcache_mem_addr = $urandom; dcache_mem_wdata = $urandom;
         dcache_mem_be = 4'($urandom_range(0, 15)); dcache_mem_we = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drive_mem();
      rdy_t r;
      if (m_busy) begin
         if (!mem_hold && m_txn != served_txn && lat == 0) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            served_txn = m_txn;
            r.who = m_owner;
            r.rdata = mem_rdata;
            exp_rdy.push_back(r);
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (lat > 0 && !mem_hold) lat--;
         end
      end else begin
         // Stray ready pulses while idle must be ignored by the arbiter.
         mem_ready = ($urandom_range(0, 7) == 0);
         mem_rdata = $urandom;
         lat = $urandom_range(0, 3);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      drive_reqs();
      drive_mem();
   endtask

   task automatic quiesce(input string name);
      for (int k = 0; k < 300 && (icache_mem_req || dcache_mem_req || m_busy); k++) step();
      chk(name, 128'({icache_mem_req, dcache_mem_req, m_busy}), 128'(0));
   endtask

   task automatic check_stats(input string name);
`ifdef MEM_PORT_ARBITER_STATS_EN
      chk({name, "_gi"}, 128'(stat_icache_grants), 128'(m_gi));
      chk({name, "_gd"}, 128'(stat_dcache_grants), 128'(m_gd));
      chk({name, "_cont"}, 128'(stat_contention), 128'(m_cont));
`else
      chk({name, "_gi"}, 128'(stat_icache_grants), 128'(0));
      chk({name, "_gd"}, 128'(stat_dcache_grants), 128'(0));
      chk({name, "_cont"}, 128'(stat_contention), 128'(0));
`endif
   endtask

   initial begin : stimulus
      #1 rst_n = 1'b0;
      repeat (3) step();
      chk("rst_mem_req", 128'(mem_req), 128'(0));
      chk("rst_mem_fields", 128'({mem_addr, mem_wdata, mem_be, mem_we}), 128'(0));
      chk("rst_readies", 128'({icache_mem_ready, dcache_mem_ready}), 128'(0));
      check_stats("rst_stats");
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Simultaneous first requests: D-cache write must go first, I-cache read next.
      step();
      icache_mem_req = 1'b1; icache_mem_addr = 32'h100;
      dcache_mem_req = 1'b1; dcache_mem_addr = 32'h2000;
      dcache_mem_wdata = 32'h12345678; dcache_mem_be = 4'h3; dcache_mem_we = 1'b1;
      quiesce("quiesce_tie");

      rand_en = 1'b1;
      keep_pct = 50;
      repeat (2000) step();
      rand_en = 1'b0;
      quiesce("quiesce_rand1");
      repeat (2) step();
      check_stats("stats1");

      // Reset in the middle of a D-cache transaction whose memory never answers.
      mem_hold = 1'b1;
      step();
      dcache_mem_req = 1'b1; dcache_mem_addr = 32'h40;
      dcache_mem_wdata = 32'hA5A5A5A5; dcache_mem_be = 4'hF; dcache_mem_we = 1'b1;
      repeat (3) step();
      chk("busy_before_reset", 128'(mem_req), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_mem_req", 128'(mem_req), 128'(0));
      chk("async_rst_dready", 128'(dcache_mem_ready), 128'(0));
      dcache_mem_req = 1'b0;
      mem_hold = 1'b0;
      repeat (2) step();
      check_stats("rst2_stats");
      @(negedge clk);
      #1 rst_n = 1'b1;
      seen_i = m_done_i;
      seen_d = m_done_d;

      // Lone I-cache read after reset.
      step();
      icache_mem_req = 1'b1; icache_mem_addr = 32'h100;
      quiesce("quiesce_lone_i");

      rand_en = 1'b1;
      keep_pct = 90;
      repeat (1500) step();
      rand_en = 1'b0;
      quiesce("quiesce_rand2");
      repeat (2) step();
      check_stats("stats2");

      chk("txn_queue_empty", 128'(exp_txn.size()), 128'(0));
      chk("rdy_queue_empty", 128'(exp_rdy.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
